// File: rtl/serializer_64bit.sv
// Parallel-to-serial transmitter: takes one WIDTH-bit word over valid/ready and
// shifts it out one bit per clock with frame markers. Define SERIALIZER_PARITY_EN
// to append an even-parity bit to every frame.
module serializer_64bit #(
  parameter int WIDTH     = 64,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             ser_last,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_bit;
`endif

  assign data_ready = (state == IDLE);

  // The registered outputs always describe the bit currently on the wire, so the
  // accept edge already loads bit 0 and the shift register holds what remains.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      ser_last    <= 1'b0;
      done        <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            state       <= SHIFT;
            bit_cnt     <= '0;
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            ser_last    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_bit  <= ^data_in;
`endif
            if (MSB_FIRST != 0) begin
              ser_out <= data_in[WIDTH-1];
              shreg   <= {data_in[WIDTH-2:0], 1'b0};
            end else begin
              ser_out <= data_in[0];
              shreg   <= {1'b0, data_in[WIDTH-1:1]};
            end
          end
        end

        SHIFT: begin
          frame_start <= 1'b0;
          if (bit_cnt == LAST_CNT) begin
`ifdef SERIALIZER_PARITY_EN
            state    <= PARITY;
            ser_out  <= parity_bit;
            ser_last <= 1'b1;
`else
            state     <= DONE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
            ser_last <= 1'b0;
`else
            ser_last <= (bit_cnt == CNT_W'(WIDTH - 2));
`endif
            if (MSB_FIRST != 0) begin
              ser_out <= shreg[WIDTH-1];
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
              ser_out <= shreg[0];
              shreg   <= {1'b0, shreg[WIDTH-1:1]};
            end
          end
        end

`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          state     <= DONE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          done      <= 1'b1;
        end
`endif

        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          bit_cnt <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_64bit.sv
// Bench for serializer_64bit: an MSB-first and an LSB-first instance share one
// stimulus stream and both are compared bit by bit against a frame model.
module tb_serializer_64bit;

  localparam int W = 64;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid;
  logic [W-1:0] data_in;

  logic m_data_ready, m_ser_out, m_ser_valid, m_frame_start, m_ser_last, m_done;
  logic l_data_ready, l_ser_out, l_ser_valid, l_frame_start, l_ser_last, l_done;

  int vectors = 0;
  int miscompares = 0;

  serializer_64bit #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(m_data_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .frame_start(m_frame_start), .ser_last(m_ser_last), .done(m_done)
  );

  serializer_64bit #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_data_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .frame_start(l_frame_start), .ser_last(l_ser_last), .done(l_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    int           exp_ones;
    logic         exp_first_msb;
    logic         exp_first_lsb;
    logic         exp_parity;
  } vec_t;

  vec_t vec_tab[6];

  // Frame model: bit i of a frame is the i-th word bit in sending order, and
  // the bit after the data (if any) is the XOR of the whole word.
  function automatic logic model_bit(input logic [W-1:0] w, input int i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic ev, input logic em, input logic el,
                              input logic efs, input logic elast, input logic edone,
                              input logic erdy);
    check_bit({tag, " msb.ser_valid"},   m_ser_valid,   ev);
    check_bit({tag, " msb.ser_out"},     m_ser_out,     em);
    check_bit({tag, " msb.frame_start"}, m_frame_start, efs);
    check_bit({tag, " msb.ser_last"},    m_ser_last,    elast);
    check_bit({tag, " msb.done"},        m_done,        edone);
    check_bit({tag, " msb.data_ready"},  m_data_ready,  erdy);
    check_bit({tag, " lsb.ser_valid"},   l_ser_valid,   ev);
    check_bit({tag, " lsb.ser_out"},     l_ser_out,     el);
    check_bit({tag, " lsb.frame_start"}, l_frame_start, efs);
    check_bit({tag, " lsb.ser_last"},    l_ser_last,    elast);
    check_bit({tag, " lsb.done"},        l_done,        edone);
    check_bit({tag, " lsb.data_ready"},  l_data_ready,  erdy);
  endtask

  // Sends one word starting from a negedge in IDLE and checks every cycle of the
  // frame. Optional: keep data_valid high, change data_in at bit switch_at, or
  // pulse reset at bit reset_at (which aborts the frame).
  task automatic apply_stimulus(input logic [W-1:0] word, input bit keep_valid,
                                input int switch_at, input logic [W-1:0] switch_word,
                                input int reset_at, output int ones,
                                output logic first_m, output logic first_l,
                                output logic par_seen);
    int waited = 0;
    ones = 0; first_m = 1'bx; first_l = 1'bx; par_seen = 1'bx;
    data_in = word;
    data_valid = 1'b1;
    while (m_data_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (m_data_ready !== 1'b1) begin
      check_bit("ready timeout", m_data_ready, 1'b1);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep_valid) data_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      check_output($sformatf("bit%0d", i), 1'b1, model_bit(word, i, 1'b1),
                   model_bit(word, i, 1'b0), i == 0, i == FRAME - 1, 1'b0, 1'b0);
      if (i == 0) begin
        first_m = m_ser_out;
        first_l = l_ser_out;
      end
      if (i < W) ones += int'(m_ser_out);
      else par_seen = m_ser_out;
      if (i == switch_at) data_in = switch_word;
      if (i == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_output("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check_output("after abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
    end
    @(negedge clk);
    check_output("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   ones;
    logic fm, fl, ps;
    logic [W-1:0] rw;

    vec_tab[0] = '{64'd9,                   2,  1'b0, 1'b1, 1'b0};
    vec_tab[1] = '{64'd4,                   1,  1'b0, 1'b0, 1'b1};
    vec_tab[2] = '{64'd7,                   3,  1'b0, 1'b1, 1'b1};
    vec_tab[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b1, 1'b0};
    vec_tab[4] = '{64'h8000_0000_0000_0000, 1,  1'b1, 1'b0, 1'b1};
    vec_tab[5] = '{64'hA5A5_0000_0000_0001, 9,  1'b1, 1'b1, 1'b1};

    // Reset held with data_valid high: nothing may be accepted.
    reset = 1'b1;
    data_valid = 1'b1;
    data_in = 64'd9;
    repeat (2) begin
      @(negedge clk);
      check_output("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    reset = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    check_output("post reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      apply_stimulus(vec_tab[k].word, 1'b0, -1, '0, -1, ones, fm, fl, ps);
      check_int($sformatf("vec%0d ones", k), ones, vec_tab[k].exp_ones);
      check_bit($sformatf("vec%0d first msb", k), fm, vec_tab[k].exp_first_msb);
      check_bit($sformatf("vec%0d first lsb", k), fl, vec_tab[k].exp_first_lsb);
`ifdef SERIALIZER_PARITY_EN
      check_bit($sformatf("vec%0d parity", k), ps, vec_tab[k].exp_parity);
`endif
    end

    // data_valid held high, data_in changed mid-frame: frame 1 stays 1, then 2 follows.
    apply_stimulus(64'd1, 1'b1, 20, 64'd2, -1, ones, fm, fl, ps);
    check_int("hold frame1 ones", ones, 1);
    apply_stimulus(64'd2, 1'b0, -1, '0, -1, ones, fm, fl, ps);
    check_int("hold frame2 ones", ones, 1);

    // Reset at bit 10 aborts the frame; the next word goes out cleanly.
    apply_stimulus(64'd5, 1'b0, -1, '0, 10, ones, fm, fl, ps);
    apply_stimulus(64'd3, 1'b0, -1, '0, -1, ones, fm, fl, ps);
    check_int("after abort ones", ones, 2);

    for (int k = 0; k < 8; k++) begin
      rw = {$urandom, $urandom};
      apply_stimulus(rw, 1'b0, -1, '0, -1, ones, fm, fl, ps);
      check_int($sformatf("rand%0d ones", k), ones, $countones(rw));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
